// File: rtl/vga_tile_renderer_pkg.sv
// vga_tile_renderer_pkg: shared mode encodings, entity codes and colour-bar table for the tile renderer.
package vga_tile_renderer_pkg;
    typedef enum logic [1:0] {
        MODE_SPRITE = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SOLID  = 2'd3
    } mode_e;
    localparam int ENT_NOTHING = 0;
    // {R,G,B} on/off per bar, bar 0 in the low bits: white, magenta, yellow, red, cyan, blue, green, black
    localparam logic [23:0] BAR_TABLE = {3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};
endpackage

// File: rtl/vga_tile_renderer_rom.sv
// tile_sprite_rom: synchronous-read sprite ROM, one-cycle latency, word = {R,G,B}.
// Contents are a fixed generated pattern: R = lx ^ ent, G = ly, B = 5*ent.
module tile_sprite_rom #(
    parameter int COLOR_W     = 4,
    parameter int ENT_W       = 2,
    parameter int TILE_W_LOG2 = 4,
    parameter int TILE_H_LOG2 = 4
) (
    input  logic                                       clk,
    input  logic [ENT_W+TILE_H_LOG2+TILE_W_LOG2-1:0]   addr,
    output logic [3*COLOR_W-1:0]                       rdata
);
    localparam int AW = ENT_W + TILE_H_LOG2 + TILE_W_LOG2;
    logic [TILE_W_LOG2-1:0] lx;
    logic [TILE_H_LOG2-1:0] ly;
    logic [ENT_W-1:0]       e;
    logic [3*COLOR_W-1:0]   data_d, data_q;
    always_comb begin
        lx     = addr[TILE_W_LOG2-1:0];
        ly     = addr[TILE_W_LOG2 +: TILE_H_LOG2];
        e      = addr[AW-1 -: ENT_W];
        data_d = {COLOR_W'(lx) ^ COLOR_W'(e), COLOR_W'(ly), COLOR_W'(e * 5)};
    end
    always_ff @(posedge clk) data_q <= data_d;
    assign rdata = data_q;
endmodule

// File: rtl/vga_tile_renderer.sv
// vga_tile_renderer: 3-stage pixel colouriser (sprite/bars/checker/solid), frame-synchronous mode switch.
// Optional GRID_OVERLAY_EN draws a dim-grey tile grid in sprite mode.
module vga_tile_renderer
    import vga_tile_renderer_pkg::*;
#(
    parameter int COLOR_W     = 4,
    parameter int ENT_W       = 2,
    parameter int TILE_W_LOG2 = 4,
    parameter int TILE_H_LOG2 = 4,
    parameter int V_RES       = 480
) (
    input  logic               iVGA_CLK,
    input  logic               reset,
    input  logic [9:0]         iVGA_X,
    input  logic [9:0]         iVGA_Y,
    input  logic               iPix_Valid,
    input  logic [ENT_W-1:0]   ent,
    input  logic [1:0]         iMode,
    output logic [COLOR_W-1:0] oRed,
    output logic [COLOR_W-1:0] oGreen,
    output logic [COLOR_W-1:0] oBlue,
    output logic               oPix_Valid
);
    localparam int RGB_W = 3 * COLOR_W;
    logic [1:0]             sync1_q, sync2_q;
    mode_e                  mode_q, mode_d, mode1_q, mode1_d, mode2_q, mode2_d;
    logic [ENT_W-1:0]       ent1_q, ent1_d;
    logic [9:0]             y1_q, y1_d;
    logic                   cx1_q, cx1_d, v1_q, v1_d, v2_q, v2_d, nz2_q, nz2_d, pv_q, pv_d;
    logic [TILE_W_LOG2-1:0] lx1_q, lx1_d;
    logic [TILE_H_LOG2-1:0] ly1_q, ly1_d;
    logic [RGB_W-1:0]       pat2_q, pat2_d, rgb_q, rgb_d, rom_data, spr;
    logic [2:0]             bar_idx, bar;
`ifdef GRID_OVERLAY_EN
    logic                   ovl2_q, ovl2_d;
    always_comb ovl2_d = lx1_q == '0 || ly1_q == '0;
    always_ff @(posedge iVGA_CLK) ovl2_q <= reset ? 1'b0 : ovl2_d;
    always_comb spr = ovl2_q ? {3{1'b0, {(COLOR_W-1){1'b1}}}} : nz2_q ? rom_data : '0;
`else
    always_comb spr = nz2_q ? rom_data : '0;
`endif
    tile_sprite_rom #(
        .COLOR_W(COLOR_W), .ENT_W(ENT_W), .TILE_W_LOG2(TILE_W_LOG2), .TILE_H_LOG2(TILE_H_LOG2)
    ) u_rom (
        .clk(iVGA_CLK), .addr({ent1_q, ly1_q, lx1_q}), .rdata(rom_data)
    );
    always_comb begin
        // the frame-start pixel itself already sees the new mode
        mode_d  = (iVGA_X == 10'd0 && iVGA_Y == 10'd0) ? mode_e'(sync2_q) : mode_q;
        mode1_d = mode_d;
        ent1_d  = ent;
        y1_d    = iVGA_Y;
        cx1_d   = iVGA_X[TILE_W_LOG2];
        v1_d    = iPix_Valid;
        lx1_d   = iVGA_X[TILE_W_LOG2-1:0];
        ly1_d   = iVGA_Y[TILE_H_LOG2-1:0];
        bar_idx = (y1_q >= 10'(V_RES)) ? 3'd7 : 3'(y1_q / 10'(V_RES / 8));
        bar     = BAR_TABLE[bar_idx*3 +: 3];
        pat2_d  = mode1_q == MODE_BARS  ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} :
                  mode1_q == MODE_CHECK ? {RGB_W{cx1_q ^ y1_q[TILE_H_LOG2]}} : {RGB_W{1'b1}};
        mode2_d = mode1_q;
        v2_d    = v1_q;
        nz2_d   = ent1_q != ENT_W'(ENT_NOTHING);
        rgb_d   = !v2_q ? '0 : mode2_q == MODE_SPRITE ? spr : pat2_q;
        pv_d    = v2_q;
    end
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            mode_q  <= MODE_SPRITE;
            mode1_q <= MODE_SPRITE;
            mode2_q <= MODE_SPRITE;
            ent1_q  <= '0;
            y1_q    <= '0;
            cx1_q   <= 1'b0;
            v1_q    <= 1'b0;
            lx1_q   <= '0;
            ly1_q   <= '0;
            pat2_q  <= '0;
            v2_q    <= 1'b0;
            nz2_q   <= 1'b0;
            rgb_q   <= '0;
            pv_q    <= 1'b0;
        end else begin
            sync1_q <= iMode;
            sync2_q <= sync1_q;
            mode_q  <= mode_d;
            mode1_q <= mode1_d;
            mode2_q <= mode2_d;
            ent1_q  <= ent1_d;
            y1_q    <= y1_d;
            cx1_q   <= cx1_d;
            v1_q    <= v1_d;
            lx1_q   <= lx1_d;
            ly1_q   <= ly1_d;
            pat2_q  <= pat2_d;
            v2_q    <= v2_d;
            nz2_q   <= nz2_d;
            rgb_q   <= rgb_d;
            pv_q    <= pv_d;
        end
    end
    assign {oRed, oGreen, oBlue} = rgb_q;
    assign oPix_Valid = pv_q;
endmodule
